// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and helpers shared by the FIFO write-side blocks.
// Rev 1.0
`default_nettype none

package fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   // Channel-ID width; a single channel still needs one bit to carry an ID.
   function automatic int ch_id_width(input int num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant, searching from the channel after the last grant.
// Rev 1.0
`default_nettype none

module rr_arbiter
   import fifo_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = ch_id_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              en,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_idx,
   output logic              grant_valid
);

   logic [CH_W-1:0] last_grant;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int off = 1; off <= NUM_CH; off++) begin
         int idx;
         idx = (int'(last_grant) + off) % NUM_CH;
         if (en && !grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant[idx]  = 1'b1;
            grant_idx   = idx[CH_W-1:0];
         end
      end
   end

   // Reset to the highest index so channel 0 is searched first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= CH_W'(NUM_CH - 1);
      else if (grant_valid)
         last_grant <= grant_idx;
   end

endmodule

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: merges NUM_CH producer channels round-robin into one tagged FIFO write stream.
// Rev 1.0
`default_nettype none

module fifo_write_arbiter
   import fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int NUM_CH     = 4,
   localparam int CH_W       = ch_id_width(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_in,
   input  logic [NUM_CH-1:0]            ch_wr_en,
   output logic [NUM_CH-1:0]            ch_full,
   output logic [NUM_CH-1:0]            ch_overflow,
   input  logic                         clr_overflow,
   output logic [DATA_WIDTH-1:0]        fifo_data_out,
   output logic [CH_W-1:0]              fifo_ch_id,
   output logic                         fifo_wr_en,
   input  logic                         fifo_full
);

   logic [DATA_WIDTH-1:0] hold_data [NUM_CH];
   logic [NUM_CH-1:0]     hold_valid;
   logic [NUM_CH-1:0]     grant;
   logic [CH_W-1:0]       grant_idx;
   logic                  grant_valid;
   logic                  load_ok;

   // Stage is free when empty or when its word leaves at this edge.
   assign load_ok = !fifo_wr_en || !fifo_full;
   assign ch_full = hold_valid;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_rr_arbiter (
      .clk         (clk),
      .rst         (rst),
      .req         (hold_valid),
      .en          (load_ok),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid  <= '0;
         ch_overflow <= '0;
         for (int i = 0; i < NUM_CH; i++)
            hold_data[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_wr_en[i] && !hold_valid[i]) begin
               hold_data[i]  <= ch_data_in[i*DATA_WIDTH +: DATA_WIDTH];
               hold_valid[i] <= 1'b1;
            end else if (grant[i]) begin
               hold_valid[i] <= 1'b0;
            end
            // A drop in the same cycle as a clear must still be recorded.
            if (ch_wr_en[i] && hold_valid[i])
               ch_overflow[i] <= 1'b1;
            else if (clr_overflow)
               ch_overflow[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_wr_en    <= 1'b0;
         fifo_data_out <= '0;
         fifo_ch_id    <= '0;
      end else if (load_ok) begin
         fifo_wr_en <= grant_valid;
         if (grant_valid) begin
            fifo_data_out <= hold_data[grant_idx];
            fifo_ch_id    <= grant_idx;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed and random checks of fifo_write_arbiter against a queue-level model.
// Rev 1.0
`default_nettype none

module tb_fifo_write_arbiter;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int CW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N*DW-1:0] ch_data_in = '0;
   logic [N-1:0]    ch_wr_en = '0;
   logic [N-1:0]    ch_full;
   logic [N-1:0]    ch_overflow;
   logic            clr_overflow = 1'b0;
   logic [DW-1:0]   fifo_data_out;
   logic [CW-1:0]   fifo_ch_id;
   logic            fifo_wr_en;
   logic            fifo_full = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   // Model: each channel is a one-deep slot; the output is a one-deep slot.
   int m_slot_cnt [N];
   int m_slot_val [N];
   int m_ovf      [N];
   int m_out_cnt;
   int m_out_val;
   int m_out_id;
   int m_last;

   always #5 clk = ~clk;

   fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
      .clk           (clk),
      .rst           (rst),
      .ch_data_in    (ch_data_in),
      .ch_wr_en      (ch_wr_en),
      .ch_full       (ch_full),
      .ch_overflow   (ch_overflow),
      .clr_overflow  (clr_overflow),
      .fifo_data_out (fifo_data_out),
      .fifo_ch_id    (fifo_ch_id),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_full     (fifo_full)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_slot_cnt[i] = 0;
         m_slot_val[i] = 0;
         m_ovf[i]      = 0;
      end
      m_out_cnt = 0;
      m_out_val = 0;
      m_out_id  = 0;
      m_last    = N - 1;
   endtask

   // One clock edge worth of behaviour, from the values present before the edge.
   task automatic model_step();
      int occupied [N];
      bit stage_free;
      for (int i = 0; i < N; i++) occupied[i] = m_slot_cnt[i];
      stage_free = (m_out_cnt == 0) || !fifo_full;
      if (stage_free) begin
         int g = -1;
         for (int k = 1; k <= N; k++)
            if (g < 0 && occupied[(m_last + k) % N] != 0) g = (m_last + k) % N;
         if (g >= 0) begin
            m_out_cnt = 1;
            m_out_val = m_slot_val[g];
            m_out_id  = g;
            m_slot_cnt[g] = 0;
            m_last = g;
         end else begin
            m_out_cnt = 0;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (ch_wr_en[i]) begin
            if (occupied[i] != 0) m_ovf[i] = 1;
            else begin
               m_slot_cnt[i] = 1;
               m_slot_val[i] = int'(ch_data_in[i*DW +: DW]);
            end
         end
         if (clr_overflow && !(ch_wr_en[i] && occupied[i] != 0)) m_ovf[i] = 0;
      end
   endtask

   task automatic compare_all();
      int exp_full = 0;
      int exp_ovf  = 0;
      for (int i = 0; i < N; i++) begin
         exp_full |= (m_slot_cnt[i] != 0) << i;
         exp_ovf  |= m_ovf[i] << i;
      end
      check("ch_full", int'(ch_full), exp_full);
      check("ch_overflow", int'(ch_overflow), exp_ovf);
      check("fifo_wr_en", int'(fifo_wr_en), m_out_cnt);
      if (m_out_cnt != 0) begin
         check("fifo_data_out", int'(fifo_data_out), m_out_val);
         check("fifo_ch_id", int'(fifo_ch_id), m_out_id);
      end
   endtask

   // Drive inputs (called just after a falling edge), clock once, check.
   task automatic cycle(input logic [N-1:0] wr, input logic [N*DW-1:0] d,
                        input logic ff, input logic clr);
      ch_wr_en     = wr;
      ch_data_in   = d;
      fifo_full    = ff;
      clr_overflow = clr;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic idle(input logic ff);
      cycle('0, '0, ff, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check("rst wr_en", int'(fifo_wr_en), 0);
      check("rst data", int'(fifo_data_out), 0);
      check("rst id", int'(fifo_ch_id), 0);
      check("rst full", int'(ch_full), 0);
      check("rst ovf", int'(ch_overflow), 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // Single write on ch2
      cycle(4'b0100, 32'h00A5_0000, 1'b0, 1'b0);
      check("single full after edge0", int'(ch_full), 4'b0100);
      check("single wr_en after edge0", int'(fifo_wr_en), 0);
      idle(1'b0);
      check("single wr_en", int'(fifo_wr_en), 1);
      check("single data", int'(fifo_data_out), 8'hA5);
      check("single id", int'(fifo_ch_id), 2);
      check("single full cleared", int'(ch_full), 0);
      idle(1'b0);
      check("single drained", int'(fifo_wr_en), 0);

      // Round robin from a fresh reset
      do_reset();
      cycle(4'b1111, 32'h1312_1110, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         idle(1'b0);
         check("rr id", int'(fifo_ch_id), k);
         check("rr data", int'(fifo_data_out), 8'h10 + k);
      end
      idle(1'b0);

      // Backpressure: 0x33 on ch1 stalled for 5 cycles, then 0x44 on ch2 follows
      do_reset();
      cycle(4'b0110, 32'h0044_3300, 1'b0, 1'b0);
      idle(1'b0);
      check("bp first id", int'(fifo_ch_id), 1);
      for (int k = 0; k < 5; k++) begin
         idle(1'b1);
         check("bp stall data", int'(fifo_data_out), 8'h33);
         check("bp stall held", int'(ch_full), 4'b0100);
      end
      idle(1'b0);
      check("bp resume data", int'(fifo_data_out), 8'h44);
      check("bp resume id", int'(fifo_ch_id), 2);
      idle(1'b0);

      // Overflow on ch3, clear, then clear coinciding with a drop
      do_reset();
      cycle(4'b1000, 32'h0100_0000, 1'b0, 1'b0);
      cycle(4'b1000, 32'h0200_0000, 1'b0, 1'b0);
      check("ovf set", int'(ch_overflow), 4'b1000);
      check("ovf delivered", int'(fifo_data_out), 8'h01);
      idle(1'b0);
      cycle('0, '0, 1'b0, 1'b1);
      check("ovf cleared", int'(ch_overflow), 0);
      cycle(4'b1000, 32'h0500_0000, 1'b0, 1'b0);
      cycle(4'b1000, 32'h0600_0000, 1'b0, 1'b1);
      check("ovf set wins", int'(ch_overflow), 4'b1000);
      idle(1'b0);
      check("ovf second data", int'(fifo_data_out), 8'h05);
      idle(1'b0);

      // Priority rotation: after ch1, ch3 beats ch0
      do_reset();
      cycle(4'b0010, 32'h0000_2100, 1'b0, 1'b0);
      cycle(4'b1001, 32'h3000_0030, 1'b0, 1'b0);
      idle(1'b0);
      check("rot first", int'(fifo_ch_id), 3);
      idle(1'b0);
      check("rot second", int'(fifo_ch_id), 0);
      idle(1'b0);

      // Reset during a stall
      cycle(4'b0001, 32'h0000_0077, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1);
      check("stall before rst", int'(fifo_wr_en), 1);
      #2;
      do_reset();
      cycle(4'b0011, 32'h0000_BBAA, 1'b0, 1'b0);
      idle(1'b0);
      check("post-rst id", int'(fifo_ch_id), 0);
      check("post-rst data", int'(fifo_data_out), 8'hAA);
      idle(1'b0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] wr;
         logic [N*DW-1:0] d;
         wr = N'($urandom & $urandom);
         d  = $urandom;
         cycle(wr, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
